// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock, presented as the
// packed 1408-bit schedule bus, plus the byte-lane S-box stage it reuses.

module subbytes #(
  parameter int NB = 16
) (
  input  logic [8*NB-1:0] data_i,
  output logic [8*NB-1:0] data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      else      p = p;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // One independent S-box per byte lane
  always_comb begin
    data_o = '0;
    for (int i = 0; i < NB; i++) begin
      data_o[8*i +: 8] = sbox(data_i[8*i +: 8]);
    end
  end

endmodule

module key_expansion #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KW-1:0]          key_in,
  output logic [(NR+1)*KW-1:0]   key_out,
  output logic                   busy,
  output logic                   key_valid,
  output logic                   done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [7:0]    rcon_q, rcon_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [KW-1:0] slot_q [0:NR];
  logic [KW-1:0] slot_d [0:NR];

  logic [KW-1:0] prev_s;
  logic [31:0]   rot_s;
  logic [31:0]   sub_word_s;
  logic [31:0]   t_s;
  logic [31:0]   n0_s, n1_s, n2_s, n3_s;
  logic [KW-1:0] next_key_s;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Only the rotated top word needs substituting for the schedule.
  subbytes #(.NB(4)) u_subword (
    .data_i (rot_s),
    .data_o (sub_word_s)
  );

  // Next round key from the previous slot
  always_comb begin
    prev_s     = slot_q[round_q - 4'd1];
    rot_s      = {prev_s[23:0], prev_s[31:24]};
    t_s        = sub_word_s ^ {rcon_q, 24'h000000};
    n0_s       = prev_s[127:96] ^ t_s;
    n1_s       = prev_s[95:64]  ^ n0_s;
    n2_s       = prev_s[63:32]  ^ n1_s;
    n3_s       = prev_s[31:0]   ^ n2_s;
    next_key_s = {n0_s, n1_s, n2_s, n3_s};
  end

  // Next-state logic for control and schedule slots
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    slot_d  = slot_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          for (int i = 1; i <= NR; i++) slot_d[i] = '0;
          slot_d[0] = key_in;
          round_d   = 4'd1;
          rcon_d    = 8'h01;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          state_d   = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        slot_d[round_q] = next_key_s;
        rcon_d  = xtime(rcon_q);
        round_d = round_q + 4'd1;
        if (round_q == 4'(NR)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          done_d  = 1'b1;
          round_d = 4'd0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i <= NR; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      slot_q  <= slot_d;
    end
  end

  for (genvar g = 0; g <= NR; g++) begin : g_pack
    assign key_out[(NR+1)*KW-1-KW*g -: KW] = slot_q[g];
  end

  assign busy      = busy_q;
  assign key_valid = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: FIPS-197 word-level reference model
// compared every cycle, plus directed known-answer and timing checks.

module tb_key_expansion;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [127:0]   key_in;
  logic [1407:0]  key_out;
  logic           busy;
  logic           key_valid;
  logic           done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ALT_KEY  = 128'hffeeddccbbaa99887766554433221100;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  key_expansion dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_out   (key_out),
    .busy      (busy),
    .key_valid (key_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    int idx;
    idx = 2047 - 8 * int'(b);
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] rc(input int i);
    case (i)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Textbook word-by-word expansion of the whole schedule, returning round r
  function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb(tmp[31:24]), sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0])} ^ {rc(i/4), 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] slot_of(input logic [1407:0] bus, input int r);
    return bus[1407 - 128*r -: 128];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: schedule fills one precomputed slot per cycle
  logic [127:0] m_slot [0:10];
  logic [127:0] m_key;
  int           m_cnt;
  logic         m_busy, m_valid, m_done;
  bit           m_live = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_cnt   <= 0;
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      m_key   <= '0;
      for (int i = 0; i <= 10; i++) m_slot[i] <= '0;
      m_live  <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          m_key     <= key_in;
          m_slot[0] <= key_in;
          for (int i = 1; i <= 10; i++) m_slot[i] <= '0;
          m_cnt     <= 10;
          m_busy    <= 1'b1;
          m_valid   <= 1'b0;
        end
      end else begin
        m_slot[11 - m_cnt] <= round_key(m_key, 11 - m_cnt);
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_busy  <= 1'b0;
          m_valid <= 1'b1;
          m_done  <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (m_live) begin
      chk("ctrl", {125'h0, busy, key_valid, done}, {125'h0, m_busy, m_valid, m_done});
      for (int i = 0; i <= 10; i++) begin
        chk($sformatf("slot%0d", i), slot_of(key_out, i), m_slot[i]);
      end
    end
  end

  task automatic start_and_wait(input logic [127:0] k, output int lat, output int busy_n);
    key_in = k;
    start  = 1'b1;
    lat    = 0;
    busy_n = 0;
    for (int c = 1; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (done) lat = c;
    end
  endtask

  int lat, bn, ndone, c0;
  int dts[$];

  initial begin
    rst = 1'b0; start = 1'b0; key_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_key_out0", slot_of(key_out, 0), 128'h0);
    chk("rst_key_out10", slot_of(key_out, 10), 128'h0);
    chk("rst_flags", {125'h0, busy, key_valid, done}, 128'h0);

    chk("model_fips_r1", round_key(FIPS_KEY, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_fips_r10", round_key(FIPS_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_zero_r10", round_key(128'h0, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    rst = 1'b1;
    @(negedge clk);

    // FIPS-197 key
    start_and_wait(FIPS_KEY, lat, bn);
    chk("fips_done_latency", 128'(lat), 128'd11);
    chk("fips_busy_cycles", 128'(bn), 128'd10);
    chk("fips_slot0", slot_of(key_out, 0), FIPS_KEY);
    chk("fips_slot1", slot_of(key_out, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_slot10", slot_of(key_out, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("fips_valid", {127'h0, key_valid}, 128'd1);

    // All-zero key
    start_and_wait(128'h0, lat, bn);
    chk("zero_done_latency", 128'(lat), 128'd11);
    chk("zero_slot1", slot_of(key_out, 1), 128'h62636363626363636263636362636363);
    chk("zero_slot10", slot_of(key_out, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // start while busy is ignored
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    key_in = ALT_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ignored_start_done_count", 128'(ndone), 128'd1);
    chk("ignored_start_slot10", slot_of(key_out, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // reset mid-expansion discards the partial schedule
    key_in = FIPS_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_slot0", slot_of(key_out, 0), 128'h0);
    chk("midrst_slot3", slot_of(key_out, 3), 128'h0);
    chk("midrst_flags", {125'h0, busy, key_valid, done}, 128'h0);
    rst = 1'b1;
    start_and_wait(FIPS_KEY, lat, bn);
    chk("post_rst_latency", 128'(lat), 128'd11);
    chk("post_rst_slot10", slot_of(key_out, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // restart from a valid schedule
    key_in = SEQ_KEY; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_valid_drop", {127'h0, key_valid}, 128'd0);
    lat = 0;
    for (int c = 2; c <= 30 && lat == 0; c++) begin
      @(negedge clk);
      if (done) lat = c;
    end
    chk("restart_latency", 128'(lat), 128'd11);
    chk("restart_slot10", slot_of(key_out, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // start held high: back-to-back expansions every 11 cycles
    key_in = ALT_KEY; start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done) dts.push_back(c);
      if (c == 34) start = 1'b0;
    end
    chk("b2b_done_count", 128'(dts.size()), 128'd4);
    c0 = 0;
    foreach (dts[i]) begin
      if (i == 0) chk("b2b_first_done", 128'(dts[i]), 128'd11);
      else        chk($sformatf("b2b_gap%0d", i), 128'(dts[i] - c0), 128'd11);
      c0 = dts[i];
    end
    chk("b2b_slot10", slot_of(key_out, 10), round_key(ALT_KEY, 10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
